// File: rtl/code_seq_arbiter.sv
// Round-robin arbiter/sequencer that shares one 4-bit Moore code detector among NREQ packet sources.
// Define CODE_SEQ_RR_EN for round-robin selection; otherwise the lowest requesting index always wins.
module code_seq_arbiter #(
  parameter int NREQ = 4,
  parameter int NIB  = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NIB*4-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic                  det_clr,
  output logic [3:0]            det_in,
  input  logic                  det_out,
  output logic                  done,
  output logic                  hit,
  output logic [IDW-1:0]        done_id
);
  localparam int PW = NIB * 4;
  localparam int CW = $clog2(NIB);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, SETTLE, REPORT} state_t;

  state_t         state_reg, state_next;
  logic [PW-1:0]  pkt_reg, pkt_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           acc_reg, acc_next;
  logic [IDW-1:0] win_reg, win_next;
  logic [IDW-1:0] sel_idx;
  logic [IDW-1:0] cand;
  logic           sel_any;
  logic [NREQ-1:0] win_onehot;

  logic [PW-1:0] pkt_of  [NREQ];
  logic [3:0]    pkt_nib [NIB];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_pkt_of
      assign pkt_of[gi] = data[gi*PW +: PW];
    end
    for (gi = 0; gi < NIB; gi++) begin : g_pkt_nib
      assign pkt_nib[gi] = pkt_reg[gi*4 +: 4];
    end
  endgenerate

  assign sel_any    = |req;
  assign win_onehot = NREQ'(1) << win_reg;

`ifdef CODE_SEQ_RR_EN
  logic [IDW-1:0] last_reg;

  // Scan from the slot after the previous winner; the first hit wins.
  always_comb begin
    sel_idx = '0;
    cand    = '0;
    for (int off = NREQ; off >= 1; off--) begin
      cand = IDW'((int'(last_reg) + off) % NREQ);
      if (req[cand]) sel_idx = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      last_reg <= IDW'(NREQ - 1);
    else if (state_reg == REPORT)
      last_reg <= win_reg;
  end
`else
  // Descending scan so the lowest set index is the last assignment.
  always_comb begin
    sel_idx = '0;
    cand    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IDW'(i);
      if (req[cand]) sel_idx = cand;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      pkt_reg   <= '0;
      cnt_reg   <= '0;
      acc_reg   <= 1'b0;
      win_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pkt_reg   <= pkt_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      win_reg   <= win_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pkt_next   = pkt_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    win_next   = win_reg;
    gnt        = '0;
    det_clr    = 1'b0;
    det_in     = 4'h0;
    done       = 1'b0;
    hit        = 1'b0;
    done_id    = '0;
    case (state_reg)
      IDLE: begin
        if (sel_any) begin
          win_next   = sel_idx;
          pkt_next   = pkt_of[sel_idx];
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        gnt        = win_onehot;
        det_clr    = 1'b1;
        acc_next   = 1'b0;
        cnt_next   = '0;
        state_next = SHIFT;
      end
      SHIFT: begin
        gnt    = win_onehot;
        det_in = pkt_nib[cnt_reg];
        // During nibble 0 the detector output still shows the clear.
        if (cnt_reg != '0) acc_next = acc_reg | det_out;
        if (cnt_reg == CW'(NIB - 1))
          state_next = SETTLE;
        else
          cnt_next = cnt_reg + 1'b1;
      end
      SETTLE: begin
        gnt        = win_onehot;
        acc_next   = acc_reg | det_out;
        state_next = REPORT;
      end
      REPORT: begin
        done       = 1'b1;
        hit        = acc_reg;
        done_id    = win_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule
